// File: rtl/motor_pwm_driver.sv
// Dual-channel H-bridge PWM driver: shared 32-count period counter, per-channel
// direction FSM with period-aligned command latching and FWD<->REV dead time.

package motor_pwm_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_REV   = 3'd2,
    ST_BRAKE = 3'd3,
    ST_DEAD  = 3'd4
  } ch_state_e;
endpackage

module motor_pwm_channel
  import motor_pwm_pkg::*;
#(
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       latch_i,
  input  logic [4:0] cnt_i,
  input  logic       cmd_a_i,
  input  logic       cmd_b_i,
  input  logic [4:0] duty_i,
  output logic       pin_a_o,
  output logic       pin_b_o,
  output logic [2:0] state_o
);

  // Counter holds DEAD_CYCLES-1 down to 0, so DEAD lasts exactly DEAD_CYCLES clocks.
  localparam int DW = (DEAD_CYCLES >= 2) ? $clog2(DEAD_CYCLES) : 1;

  ch_state_e     state_q, state_d;
  ch_state_e     target_q, target_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [4:0]    duty_q, duty_d;
  logic          pin_a_q, pin_a_d;
  logic          pin_b_q, pin_b_d;
  ch_state_e     cmd;
  logic          on;
  logic          reversal;

  function automatic ch_state_e decode(input logic a, input logic b);
    case ({a, b})
      2'b10:   return ST_FWD;
      2'b01:   return ST_REV;
      2'b11:   return ST_BRAKE;
      default: return ST_IDLE;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d  = state_q;
    target_d = target_q;
    dead_d   = dead_q;
    duty_d   = duty_q;
    pin_a_d  = 1'b0;
    pin_b_d  = 1'b0;
    cmd      = decode(cmd_a_i, cmd_b_i);
    on       = (cnt_i < duty_q);
    reversal = ((state_q == ST_FWD) && (cmd == ST_REV)) ||
               ((state_q == ST_REV) && (cmd == ST_FWD));

    case (state_q)
      ST_FWD:   pin_a_d = on;
      ST_REV:   pin_b_d = on;
      ST_BRAKE: begin
        pin_a_d = 1'b1;
        pin_b_d = 1'b1;
      end
      default: ;
    endcase

    if (!run_i) begin
      state_d  = ST_IDLE;
      target_d = ST_IDLE;
      dead_d   = '0;
      duty_d   = '0;
      pin_a_d  = 1'b0;
      pin_b_d  = 1'b0;
    end else begin
      if (latch_i) duty_d = duty_i;

      if (state_q == ST_DEAD) begin
        // A command latched during dead time retargets without restarting the wait.
        if (latch_i) target_d = cmd;
        if (dead_q == '0) state_d = target_d;
        else              dead_d  = dead_q - DW'(1);
      end else if (latch_i) begin
        if (reversal) begin
          state_d  = ST_DEAD;
          target_d = cmd;
          dead_d   = DW'(DEAD_CYCLES - 1);
        end else begin
          state_d = cmd;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= ST_IDLE;
      dead_q   <= '0;
      duty_q   <= '0;
      pin_a_q  <= 1'b0;
      pin_b_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      target_q <= target_d;
      dead_q   <= dead_d;
      duty_q   <= duty_d;
      pin_a_q  <= pin_a_d;
      pin_b_q  <= pin_b_d;
    end
  end

  assign pin_a_o = pin_a_q;
  assign pin_b_o = pin_b_q;
  assign state_o = state_q;

endmodule

module motor_pwm_driver #(
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fault,
  input  logic       m1_a,
  input  logic       m1_b,
  input  logic       m2_a,
  input  logic       m2_b,
  input  logic [4:0] dc1,
  input  logic [4:0] dc2,
  output logic       pwm1_a,
  output logic       pwm1_b,
  output logic       pwm2_a,
  output logic       pwm2_b,
  output logic       period_tick,
  output logic [2:0] ch1_state,
  output logic [2:0] ch2_state
);

  logic [4:0] cnt_q, cnt_d;
  logic       tick_q, tick_d;
  logic       run;
  logic       latch;

  // Fault dominates enable; either one parks the counter at 0 for a clean restart.
  assign run    = enable & ~fault;
  assign latch  = run & (cnt_q == 5'd31);
  assign cnt_d  = run ? (cnt_q + 5'd1) : 5'd0;
  assign tick_d = latch;

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign period_tick = tick_q;

  motor_pwm_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_ch1 (
    .clk_i   (clk_3125KHz),
    .rst_n   (rst_n),
    .run_i   (run),
    .latch_i (latch),
    .cnt_i   (cnt_q),
    .cmd_a_i (m1_a),
    .cmd_b_i (m1_b),
    .duty_i  (dc1),
    .pin_a_o (pwm1_a),
    .pin_b_o (pwm1_b),
    .state_o (ch1_state)
  );

  motor_pwm_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_ch2 (
    .clk_i   (clk_3125KHz),
    .rst_n   (rst_n),
    .run_i   (run),
    .latch_i (latch),
    .cnt_i   (cnt_q),
    .cmd_a_i (m2_a),
    .cmd_b_i (m2_b),
    .duty_i  (dc2),
    .pin_a_o (pwm2_a),
    .pin_b_o (pwm2_b),
    .state_o (ch2_state)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: per-clock reference model, a table of
// steady-state duty/direction vectors, hand sequences for corner cases, random soak.

module tb_motor_pwm_driver;

  localparam int DEAD = 16;

  logic       clk = 1'b0;
  logic       rst_n, enable, fault;
  logic       m1_a, m1_b, m2_a, m2_b;
  logic [4:0] dc1, dc2;
  logic       pwm1_a, pwm1_b, pwm2_a, pwm2_b, period_tick;
  logic [2:0] ch1_state, ch2_state;

  always #10 clk = ~clk;

  motor_pwm_driver #(.DEAD_CYCLES(DEAD)) dut (
    .clk_3125KHz (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fault       (fault),
    .m1_a        (m1_a),
    .m1_b        (m1_b),
    .m2_a        (m2_a),
    .m2_b        (m2_b),
    .dc1         (dc1),
    .dc2         (dc2),
    .pwm1_a      (pwm1_a),
    .pwm1_b      (pwm1_b),
    .pwm2_a      (pwm2_a),
    .pwm2_b      (pwm2_b),
    .period_tick (period_tick),
    .ch1_state   (ch1_state),
    .ch2_state   (ch2_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: time is an edge index, cnt is clocks-since-restart mod 32,
  // dead time is an absolute edge index at which the pending direction takes over.
  int cyc;
  int m_cnt, m_tick;
  int m_duty[2], m_mode[2], m_target[2], m_dead_end[2], m_pa[2], m_pb[2];

  function automatic int cmd_of(input logic a, input logic b);
    if (a && !b) return 1;
    if (!a && b) return 2;
    if (a && b)  return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_tick = 0;
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0; m_mode[c] = 0; m_target[c] = 0;
      m_dead_end[c] = 0; m_pa[c] = 0; m_pb[c] = 0;
    end
  endtask

  task automatic model_step();
    int  cmd[2];
    int  dc[2];
    bit  hi;
    bit  latch;
    cyc++;
    if (!enable || fault) begin
      model_reset();
      return;
    end
    cmd[0] = cmd_of(m1_a, m1_b);
    cmd[1] = cmd_of(m2_a, m2_b);
    dc[0]  = int'(dc1);
    dc[1]  = int'(dc2);
    for (int c = 0; c < 2; c++) begin
      hi = (m_cnt < m_duty[c]);
      m_pa[c] = ((m_mode[c] == 3) || (m_mode[c] == 1 && hi)) ? 1 : 0;
      m_pb[c] = ((m_mode[c] == 3) || (m_mode[c] == 2 && hi)) ? 1 : 0;
    end
    latch  = (m_cnt == 31);
    m_tick = latch ? 1 : 0;
    for (int c = 0; c < 2; c++) begin
      if (latch) m_duty[c] = dc[c];
      if (m_mode[c] == 4) begin
        if (latch) m_target[c] = cmd[c];
        if (cyc == m_dead_end[c]) m_mode[c] = m_target[c];
      end else if (latch) begin
        if ((m_mode[c] == 1 && cmd[c] == 2) || (m_mode[c] == 2 && cmd[c] == 1)) begin
          m_mode[c]     = 4;
          m_target[c]   = cmd[c];
          m_dead_end[c] = cyc + DEAD;
        end else begin
          m_mode[c] = cmd[c];
        end
      end
    end
    m_cnt = (m_cnt + 1) % 32;
  endtask

  task automatic compare_all();
    check("pwm1_a", pwm1_a, m_pa[0]);
    check("pwm1_b", pwm1_b, m_pb[0]);
    check("pwm2_a", pwm2_a, m_pa[1]);
    check("pwm2_b", pwm2_b, m_pb[1]);
    check("period_tick", period_tick, m_tick);
    check("ch1_state", ch1_state, m_mode[0]);
    check("ch2_state", ch2_state, m_mode[1]);
  endtask

  task automatic check_all_zero(input string prefix);
    check({prefix, "_pwm1_a"}, pwm1_a, 0);
    check({prefix, "_pwm1_b"}, pwm1_b, 0);
    check({prefix, "_pwm2_a"}, pwm2_a, 0);
    check({prefix, "_pwm2_b"}, pwm2_b, 0);
    check({prefix, "_tick"}, period_tick, 0);
    check({prefix, "_ch1_state"}, ch1_state, 0);
    check({prefix, "_ch2_state"}, ch2_state, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_all();
  endtask

  task automatic restart();
    fault = 1'b1;
    tick();
    fault = 1'b0;
  endtask

  task automatic count_window(input int n, output int na1, output int nb1,
                              output int na2, output int nb2);
    na1 = 0; nb1 = 0; na2 = 0; nb2 = 0;
    for (int i = 0; i < n; i++) begin
      na1 += int'(pwm1_a); nb1 += int'(pwm1_b);
      na2 += int'(pwm2_a); nb2 += int'(pwm2_b);
      tick();
    end
  endtask

  typedef struct {
    logic       a1, b1;
    logic [4:0] d1;
    logic       a2, b2;
    logic [4:0] d2;
    int         ha1, hb1, ha2, hb2;
    int         st1, st2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int na1, nb1, na2, nb2;
    int n, dead_clk, dead_hi, overlap, adj, zeros;
    logic prev_a, prev_b;

    vecs[0] = '{1'b1, 1'b0, 5'd8,  1'b0, 1'b0, 5'd5,  8,  0,  0,  0,  1, 0};
    vecs[1] = '{1'b0, 1'b1, 5'd20, 1'b1, 1'b0, 5'd31, 0,  20, 31, 0,  2, 1};
    vecs[2] = '{1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 5'd0,  32, 32, 0,  0,  3, 1};
    vecs[3] = '{1'b0, 1'b0, 5'd17, 1'b0, 1'b1, 5'd1,  0,  0,  0,  1,  0, 2};
    vecs[4] = '{1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 5'd0,  31, 0,  32, 32, 1, 3};
    vecs[5] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd31, 0,  0,  0,  31, 1, 2};

    cyc = 0;
    rst_n = 1'b0; enable = 1'b0; fault = 1'b0;
    m1_a = 1'b0; m1_b = 1'b0; m2_a = 1'b0; m2_b = 1'b0;
    dc1 = 5'd0; dc2 = 5'd0;
    model_reset();
    #25;
    check_all_zero("reset");
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    // Steady-state high-clock counts per 32-clock window.
    for (int v = 0; v < 6; v++) begin
      restart();
      m1_a = vecs[v].a1; m1_b = vecs[v].b1; dc1 = vecs[v].d1;
      m2_a = vecs[v].a2; m2_b = vecs[v].b2; dc2 = vecs[v].d2;
      repeat (40) tick();
      count_window(32, na1, nb1, na2, nb2);
      check($sformatf("vec%0d_hi1a", v), na1, vecs[v].ha1);
      check($sformatf("vec%0d_hi1b", v), nb1, vecs[v].hb1);
      check($sformatf("vec%0d_hi2a", v), na2, vecs[v].ha2);
      check($sformatf("vec%0d_hi2b", v), nb2, vecs[v].hb2);
      check($sformatf("vec%0d_st1", v), ch1_state, vecs[v].st1);
      check($sformatf("vec%0d_st2", v), ch2_state, vecs[v].st2);
    end

    // Duty change mid-period only affects the following period.
    restart();
    m1_a = 1'b1; m1_b = 1'b0; dc1 = 5'd8;
    m2_a = 1'b0; m2_b = 1'b0; dc2 = 5'd0;
    repeat (33) tick();
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(pwm1_a);
      if (m_cnt == 10) dc1 = 5'd20;
      tick();
    end
    check("dc_change_current", n, 8);
    count_window(32, na1, nb1, na2, nb2);
    check("dc_change_next", na1, 20);

    // FWD -> REV reversal with dead time.
    restart();
    m1_a = 1'b1; m1_b = 1'b0; dc1 = 5'd31;
    repeat (65) tick();
    m1_a = 1'b0; m1_b = 1'b1;
    dead_clk = 0; dead_hi = 0; overlap = 0; adj = 0; na1 = 0; nb1 = 0;
    prev_a = pwm1_a; prev_b = pwm1_b;
    for (int i = 0; i < 96; i++) begin
      if (ch1_state == 3'd4) begin
        dead_clk++;
        if (pwm1_a || pwm1_b) dead_hi++;
      end
      if (pwm1_a && pwm1_b) overlap++;
      if ((prev_a && pwm1_b) || (prev_b && pwm1_a)) adj++;
      prev_a = pwm1_a; prev_b = pwm1_b;
      na1 += int'(pwm1_a); nb1 += int'(pwm1_b);
      tick();
    end
    check("rev_dead_clocks", dead_clk, DEAD);
    check("rev_dead_pins_high", dead_hi, 0);
    check("rev_overlap", overlap, 0);
    check("rev_adjacent", adj, 0);
    check("rev_fwd_highs", na1, 31);
    check("rev_rev_highs", nb1, 46);

    // Fault pulse while a pin is high, then restart behaviour.
    restart();
    m1_a = 1'b1; m1_b = 1'b0; dc1 = 5'd8;
    repeat (67) tick();
    check("fault_pre_pin", pwm1_a, 1);
    fault = 1'b1;
    tick();
    check_all_zero("fault");
    repeat (3) tick();
    fault = 1'b0;
    zeros = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (!pwm1_a && !pwm1_b) zeros++;
    end
    check("fault_zero_clocks", zeros, 32);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      n += int'(pwm1_a);
    end
    check("fault_resume_highs", n, 8);

    // Asynchronous reset in the middle of dead time.
    restart();
    m1_a = 1'b1; m1_b = 1'b0; dc1 = 5'd31;
    repeat (65) tick();
    m1_a = 1'b0; m1_b = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (ch1_state == 3'd4) break;
      tick();
    end
    check("dead_reached", ch1_state, 4);
    repeat (3) tick();
    #4;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_dead");
    #2;
    rst_n = 1'b1;
    model_reset();
    repeat (40) tick();

    // Random soak against the model.
    for (int i = 0; i < 1500; i++) begin
      if (enable) begin
        if ($urandom_range(0, 199) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable = 1'b1;
      end
      if (!fault && $urandom_range(0, 149) == 0) fault = 1'b1;
      else if (fault && $urandom_range(0, 3) == 0) fault = 1'b0;
      if ($urandom_range(0, 39) == 0) {m1_a, m1_b} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) {m2_a, m2_b} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) dc1 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) dc2 = 5'($urandom_range(0, 31));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 16, meaning clocks both H-bridge pins of a channel are held low on a FWD/REV reversal.
REQ-002 SHALL have clk_3125KHz  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have enable  in  1  run enable, sourced from switch_key.
REQ-005 SHALL have fault  in  1  electromagnet fault override, EU_FAULT_FLAG.
REQ-006 SHALL have m1_a, m1_b, m2_a, m2_b  in  1 each  direction commands for motor 1 (left) and motor 2 (right).
REQ-007 SHALL have dc1, dc2  in  5 each  duty commands, 0..31 counts of a 32-count period.
REQ-008 SHALL have pwm1_a, pwm1_b, pwm2_a, pwm2_b  out  1 each  registered H-bridge pin drives.
REQ-009 SHALL have period_tick  out  1  one-clock pulse at each period start.
REQ-010 SHALL have ch1_state, ch2_state  out  3 each  FSM state: 0 IDLE, 1 FWD, 2 REV, 3 BRAKE, 4 DEAD.

Function
REQ-011 SHALL run a 5-bit period counter cnt that increments each clock while enable=1 and fault=0, wrapping 31->0 with no idle cycle.
REQ-012 SHALL assert period_tick, registered, for exactly the one clock during which cnt==0.
REQ-013 SHALL sample dcN and {mN_a,mN_b} into per-channel shadow registers only on the edge where cnt==31; mid-period input changes SHALL NOT affect the running period.
REQ-014 SHALL decode {a,b}: 10 FWD, 01 REV, 00 IDLE (coast), 11 BRAKE.
REQ-015 SHALL, in FWD, drive pwmN_a = (cnt < duty) and pwmN_b = 0; in REV, pwmN_a = 0 and pwmN_b = (cnt < duty); in IDLE and DEAD, both 0; in BRAKE, both 1 regardless of duty.
REQ-016 SHALL register pin outputs with one clock of latency from cnt; each period SHALL contain exactly duty high clocks: duty 0 gives always low, duty 31 gives 31 of 32.
REQ-017 SHALL apply the new state at the latch edge on any sampled command change except FWD<->REV.
REQ-018 SHALL, on a FWD<->REV change, enter DEAD for DEAD_CYCLES clocks, then enter the most recently latched target. Commands latched during DEAD SHALL replace the target. cnt SHALL keep running with no realignment.
REQ-019 SHALL ensure pwmN_a and pwmN_b are never both 1 except in BRAKE, and that no FWD-high clock is ever adjacent to a REV-high clock.
REQ-020 SHALL, when fault=1, drive all pins 0 on the next edge, force both FSMs to IDLE, clear shadow duties, hold cnt at 0, and suppress period_tick.
REQ-021 SHALL, when fault or enable deasserts, restart cnt from 0; the first 32 clocks output 0, and the first latch occurs at cnt==31.
REQ-022 SHALL, when enable=0, behave as REQ-020 without any fault semantics; enable and fault simultaneously active SHALL equal fault alone.
REQ-023 SHALL handle both channels independently, sharing only cnt and period_tick.

Reset
REQ-024 SHALL, on rst_n=0 and without waiting for a clock, set cnt=0, shadow duties=0, both FSMs IDLE, dead counters=0, all pwm outputs 0, period_tick=0, ch states 0, including when reset is asserted mid-DEAD or mid-pulse.
REQ-025 SHALL resume per REQ-021 after rst_n deasserts.

Verification
REQ-026 SHALL verify: enable=1, m1={1,0}, dc1=8 -> from the second period, pwm1_a high 8 consecutive clocks per 32, pwm1_b=0, ch1_state=1.
REQ-027 SHALL verify: dc1 8->20 at cnt==10 -> current period 8 high clocks, next period 20.
REQ-028 SHALL verify: m1 {1,0}->{0,1}, dc1=31 -> ch1_state=4, both pins low for 16 clocks, then pwm1_b pulses; pwm1_a&pwm1_b is never 1.
REQ-029 SHALL verify: fault pulse at cnt==3 with pin high -> pins 0 next clock, states 0; after release, 32 zero clocks, then resume.
REQ-030 SHALL verify: m2={1,1} -> both pins 1 continuously; dc2=0 with FWD -> pins 0 all period.
REQ-031 SHALL verify: rst_n low mid-DEAD -> all outputs 0 before the next clock edge.
